link_buffer: RTL and testbench
==============================

// Module: link_buffer
// PURPOSE
//  - Elastic FIFO stage between a router tx channel port and the rx channel port of the
//    next router (or a packet sink). One instance per directed link.
//  - Absorbs downstream back-pressure and decouples the two routers' handshake timing.
//  - Flits pass through unmodified and in order; the block never inspects destination bits.
// PARAMETERS
//  SIZE        8   flit width in bits (matches router SIZE)
//  DEPTH       4   FIFO entries; power of two, >= 2
//  PTR_BITS    2   log2(DEPTH); must be set consistently with DEPTH
//  ID          0   link index, used only in debug messages
// PORTS
//  clk        in   1            clock; all state changes on posedge
//  reset      in   1            synchronous, active-high reset
//  in_req     in   1            upstream (router tx_ch_req) flit valid
//  in_ack     out  1            upstream accept (to router tx_ch_ack)
//  in_data    in   SIZE         upstream flit (router tx_ch_data slice)
//  out_req    out  1            downstream flit valid (to router rx_ch_req)
//  out_ack    in   1            downstream accept (router rx_ch_ack)
//  out_data   out  SIZE         downstream flit (router rx_ch_data slice)
//  count      out  PTR_BITS+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Handshake, both sides: a transfer occurs at a posedge where req && ack are both 1.
//    The sender holds req and data stable until that edge.
//  - Storage: mem[DEPTH] of SIZE bits, wr_ptr/rd_ptr PTR_BITS wide with natural binary wrap,
//    occupancy register cnt of PTR_BITS+1 bits driving count.
//  - in_ack   = (cnt != DEPTH); combinational from registered state only (not from in_req).
//  - out_req  = (cnt != 0); out_data = mem[rd_ptr]. Both derive from registered state only.
//  - push = in_req & in_ack: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1.
//  - pop  = out_req & out_ack: rd_ptr <= rd_ptr+1.
//  - cnt  <= cnt + push - pop, computed at PTR_BITS+1 width.
//  - Latency: a flit pushed at edge N is presented on out_req/out_data from edge N onward.
//    It is poppable at edge N+1 at the earliest. There is no combinational in->out path.
//  - Throughput: 1 flit/cycle sustained when the downstream acks continuously.
//  - Empty (cnt=0): out_req=0; push only; a same-cycle pop is impossible.
//  - Full (cnt=DEPTH): in_ack=0; no push even if pop happens the same cycle.
//    in_ack reasserts the cycle after the pop.
//  - Partial occupancy with push and pop in the same cycle: cnt unchanged, both pointers advance.
//  - Pointer wrap: wr_ptr/rd_ptr roll from DEPTH-1 to 0 with no special case; ordering is preserved.
//  - Reset, including mid-transfer: wr_ptr=0, rd_ptr=0, cnt=0.
//    During reset and the cycle after it: in_ack=1, out_req=0, count=0.
//    mem contents are not reset; out_data is don't-care while out_req=0.
//    In-flight flits are discarded.
//  - in_data is ignored while in_ack=0. out_ack is ignored while out_req=0.
// CONFIGURATION
//  - LINK_BUFFER_STATS_EN defined: adds output flit_total [31:0].
//    flit_total resets to 0 and increments by 1 on every pop, wrapping at 2^32.
//    Also adds output stall_cycles [31:0], reset to 0.
//    stall_cycles increments each cycle with in_req=1 and in_ack=0, and saturates at 32'hFFFFFFFF.
//    A $display line with ID and the flit value is printed on each pop.
//  - LINK_BUFFER_STATS_EN undefined: neither port exists, no counters, no prints.
//    The core behaviour is identical in both builds.
// TESTING
//  1. Reset, then idle -> in_ack=1, out_req=0, count=0 for >=3 cycles.
//  2. Push 8'hA5 with out_ack=0 -> next cycle out_req=1, out_data=8'hA5, count=1.
//     Assert out_ack 1 cycle -> count=0, out_req=0.
//  3. DEPTH=4, out_ack=0, push 8'h01..8'h05 back-to-back.
//     Required: 4 accepted, in_ack=0, count=4, 8'h05 held by the sender.
//     Then out_ack=1 -> pops 01,02,03,04,05 in order; in_ack reasserts 1 cycle after the first pop.
//  4. in_req=1 and out_ack=1 continuously for 20 flits with incrementing data.
//     Required: 1 flit/cycle after first-flit latency, count stays 1, pointers wrap 5x, no loss or reorder.
//  5. Fill to count=3, assert reset 1 cycle mid-handshake -> next cycle count=0, out_req=0, in_ack=1.
//     A later push of 8'h3C is the first flit out.
//  6. LINK_BUFFER_STATS_EN build, scenario 3.
//     Required: flit_total=5 and stall_cycles equal to the cycles 8'h05 waited.
//     Non-stats build: scenario 3 output is bit-identical.

Source files
------------

// File: rtl/link_buffer.sv
// Elastic valid/ack FIFO between two router channel ports, one per directed link.
// Optional counters and pop trace are enabled with LINK_BUFFER_STATS_EN.
module link_buffer #(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2,
    parameter int ID       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_req,
    output logic                in_ack,
    input  logic [SIZE-1:0]     in_data,
    output logic                out_req,
    input  logic                out_ack,
    output logic [SIZE-1:0]     out_data,
    output logic [PTR_BITS:0]   count
`ifdef LINK_BUFFER_STATS_EN
    ,
    output logic [31:0]         flit_total,
    output logic [31:0]         stall_cycles
`endif
);

    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);

    if (DEPTH != (1 << PTR_BITS) || DEPTH < 2 || ID < 0) begin : g_bad_cfg
        $error("link_buffer: DEPTH must be 2**PTR_BITS and >= 2, ID >= 0");
    end

    logic [SIZE-1:0]     mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   cnt_q, cnt_d;
    logic                push;
    logic                pop;

    // Reset masks the handshake outputs so neither side sees stale occupancy.
    assign in_ack   = reset | (cnt_q != FULL_CNT);
    assign out_req  = ~reset & (cnt_q != '0);
    assign out_data = mem_q[rd_ptr_q];
    assign count    = reset ? '0 : cnt_q;

    assign push = in_req & in_ack & ~reset;
    assign pop  = out_req & out_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        cnt_d = cnt_q + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef LINK_BUFFER_STATS_EN
    logic [31:0] flit_total_q, flit_total_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        flit_total_d = flit_total_q + 32'(pop);
        stall_d      = stall_q;
        if (in_req && !in_ack && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_total_q <= '0;
            stall_q      <= '0;
        end else begin
            flit_total_q <= flit_total_d;
            stall_q      <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            $display("link_buffer[%0d] pop flit %h", ID, out_data);
        end
    end

    assign flit_total   = flit_total_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_link_buffer.sv
// Bench for link_buffer: vector table plus a queue-based reference of the FIFO.
// Build with LINK_BUFFER_STATS_EN defined to also check the statistics counters.
module tb_link_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_req = 1'b0;
    logic       in_ack;
    logic [7:0] in_data = 8'h00;
    logic       out_req;
    logic       out_ack = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
`ifdef LINK_BUFFER_STATS_EN
    logic [31:0] flit_total;
    logic [31:0] stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [7:0] sb[$];
    logic [7:0] out_log[$];

    always #5 clk = ~clk;

    link_buffer #(.SIZE(8), .DEPTH(4), .PTR_BITS(2), .ID(0)) dut (
        .clk(clk),
        .reset(reset),
        .in_req(in_req),
        .in_ack(in_ack),
        .in_data(in_data),
        .out_req(out_req),
        .out_ack(out_ack),
        .out_data(out_data),
        .count(count)
`ifdef LINK_BUFFER_STATS_EN
        ,
        .flit_total(flit_total),
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: expected flits queued on accept, DUT output logged on pop.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            bit full;
            bit empty;
            full  = (sb.size() == 4);
            empty = (sb.size() == 0);
            if (!empty && out_ack) begin
                out_log.push_back(out_data);
                void'(sb.pop_front());
            end
            if (in_req && !full) begin
                sb.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_in_ack", 32'(in_ack), 32'(sb.size() != 4));
            chk("sb_out_req", 32'(out_req), 32'(sb.size() != 0));
            chk("sb_count", 32'(count), 32'(sb.size()));
            if (sb.size() != 0) begin
                chk("sb_out_data", 32'(out_data), 32'(sb[0]));
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       ireq;
        logic [7:0] idata;
        logic       oack;
        logic       e_ack;
        logic       e_req;
        logic [2:0] e_cnt;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic ireq, input logic [7:0] idata,
                                input logic oack, input logic e_ack, input logic e_req,
                                input logic [2:0] e_cnt, input logic [7:0] e_data);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.idata = idata; v.oack = oack;
        v.e_ack = e_ack; v.e_req = e_req; v.e_cnt = e_cnt; v.e_data = e_data;
        return v;
    endfunction

    // Starts just after a negedge; returns at the following negedge.
    task automatic cyc(input logic rst, input logic ireq, input logic [7:0] idata,
                       input logic oack);
        #1;
        reset   = rst;
        in_req  = ireq;
        in_data = idata;
        out_ack = oack;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s3_first;
        int s3_last;
        int base;
`ifdef LINK_BUFFER_STATS_EN
        logic [31:0] ft0;
        logic [31:0] st0;
        ft0 = '0;
        st0 = '0;
`endif
        // reset and idle
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        // single flit
        vt.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 1, 8'hA5));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
        // fill past full, sender holds 05, then drain
        s3_first = vt.size();
        vt.push_back(mk(0, 1, 8'h01, 0, 1, 1, 1, 8'h01));
        vt.push_back(mk(0, 1, 8'h02, 0, 1, 1, 2, 8'h01));
        vt.push_back(mk(0, 1, 8'h03, 0, 1, 1, 3, 8'h01));
        vt.push_back(mk(0, 1, 8'h04, 0, 0, 1, 4, 8'h01));
        vt.push_back(mk(0, 1, 8'h05, 0, 0, 1, 4, 8'h01));
        vt.push_back(mk(0, 1, 8'h05, 0, 0, 1, 4, 8'h01));
        vt.push_back(mk(0, 1, 8'h05, 1, 1, 1, 3, 8'h02));
        vt.push_back(mk(0, 1, 8'h05, 1, 1, 1, 3, 8'h03));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 2, 8'h04));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h05));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
        s3_last = vt.size() - 1;

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
`ifdef LINK_BUFFER_STATS_EN
            if (i == s3_first) begin
                ft0 = flit_total;
                st0 = stall_cycles;
            end
`endif
            cyc(vt[i].rst, vt[i].ireq, vt[i].idata, vt[i].oack);
            chk($sformatf("v%0d_in_ack", i), 32'(in_ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_out_req", i), 32'(out_req), 32'(vt[i].e_req));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            if (vt[i].e_req) begin
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vt[i].e_data));
            end
            if (i == s3_last) begin
`ifdef LINK_BUFFER_STATS_EN
                chk("stats_flit_total", flit_total - ft0, 32'd5);
                chk("stats_stall_cycles", stall_cycles - st0, 32'd3);
`endif
            end
            chk_en = 1'b1;
        end
        chk("s3_pop_count", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3_order%0d", i), 32'(out_log[i+1]), 32'(i + 1));
        end

        // continuous streaming: one flit per cycle, occupancy pinned at 1
        base = out_log.size();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 8'(8'h10 + i), 1);
            chk($sformatf("s4_count%0d", i), 32'(count), 32'd1);
            chk($sformatf("s4_pops%0d", i), 32'(out_log.size() - base), 32'(i));
        end
        cyc(0, 0, 8'h00, 1);
        chk("s4_drained", 32'(count), 32'd0);
        chk("s4_total", 32'(out_log.size() - base), 32'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("s4_order%0d", i), 32'(out_log[base+i]), 32'(8'h10 + i));
        end

        // reset in the middle of a handshake
        cyc(0, 1, 8'h50, 0);
        cyc(0, 1, 8'h51, 0);
        cyc(0, 1, 8'h52, 0);
        chk("s5_fill", 32'(count), 32'd3);
        #1;
        reset   = 1'b1;
        in_req  = 1'b1;
        in_data = 8'h53;
        out_ack = 1'b1;
        #1;
        chk("s5_during_ack", 32'(in_ack), 32'd1);
        chk("s5_during_req", 32'(out_req), 32'd0);
        chk("s5_during_cnt", 32'(count), 32'd0);
        @(negedge clk);
        chk("s5_after_cnt", 32'(count), 32'd0);
        chk("s5_after_req", 32'(out_req), 32'd0);
        cyc(0, 0, 8'h00, 0);
        chk("s5_idle_ack", 32'(in_ack), 32'd1);
        chk("s5_idle_cnt", 32'(count), 32'd0);
        base = out_log.size();
        cyc(0, 1, 8'h3C, 0);
        chk("s5_3c_req", 32'(out_req), 32'd1);
        chk("s5_3c_data", 32'(out_data), 32'h3C);
        cyc(0, 0, 8'h00, 1);
        chk("s5_3c_pops", 32'(out_log.size() - base), 32'd1);
        if (out_log.size() > base) begin
            chk("s5_first_out", 32'(out_log[base]), 32'h3C);
        end
        chk("s5_empty", 32'(count), 32'd0);

        cyc(0, 0, 8'h00, 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
